// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: shared mode encoding and default rates for the CPU clock controller
package clk_ctrl_pkg;
  typedef enum logic [1:0] {HALT = 2'd0, RUN = 2'd1, STEP = 2'd2, CPU_HALT = 2'd3} mode_t;
  localparam int unsigned DEF_DIV0 = 500000;
  localparam int unsigned DEF_DIV1 = 50000;
  localparam int unsigned DEF_DIV2 = 5000;
  localparam int unsigned DEF_DIV3 = 1;
  localparam int unsigned DEF_DEB_CYCLES = 1000000;
  // Terminal divider count; a zero divisor is treated as one
  function automatic logic [31:0] term(input int unsigned div);
    return div == 0 ? 32'd0 : div - 1;
  endfunction
endpackage

// File: rtl/debounce.sv
// debounce: 2-flop synchronizer, stability counter and rising-edge pulse for a board button
module debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic rise_o
);
  localparam int W = DEB_CYCLES < 2 ? 1 : $clog2(DEB_CYCLES);
  localparam logic [W-1:0] LIM = W'(DEB_CYCLES == 0 ? 0 : DEB_CYCLES - 1);
  logic s0_q, s1_q, lvl_q, rise_q, diff, flip;
  logic [W-1:0] cnt_q;
  assign diff = s1_q != lvl_q;
  assign flip = diff && cnt_q == LIM;
  assign rise_o = rise_q;
  // Level follows the synchronized input only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s0_q   <= btn_i;
      s1_q   <= s0_q;
      cnt_q  <= diff && !flip ? cnt_q + 1'b1 : '0;
      lvl_q  <= flip ? s1_q : lvl_q;
      rise_q <= flip & s1_q;
    end
  end
endmodule

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: run/halt/single-step clock-enable generator for the CPU domain
module cpu_clock_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned DIV0       = DEF_DIV0,
  parameter int unsigned DIV1       = DEF_DIV1,
  parameter int unsigned DIV2       = DEF_DIV2,
  parameter int unsigned DIV3       = DEF_DIV3,
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic        clk_board,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic [1:0]  div_sel,
  input  logic        halt_req,
  output logic        cpu_ce,
  output logic [1:0]  mode,
  output logic [31:0] tick_cnt
);
  localparam logic [31:0] T0 = term(DIV0);
  localparam logic [31:0] T1 = term(DIV1);
  localparam logic [31:0] T2 = term(DIV2);
  localparam logic [31:0] T3 = term(DIV3);
  mode_t       mode_q;
  logic        run_s0_q, run_s1_q, ce_q, step_ev;
  logic [1:0]  sel_q;
  logic [31:0] cnt_q, tick_q, tsel;
  debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
    .clk_i (clk_board),
    .rst_ni(rst_n),
    .btn_i (step_btn),
    .rise_o(step_ev)
  );
  assign tsel = div_sel == 2'd0 ? T0 : div_sel == 2'd1 ? T1 : div_sel == 2'd2 ? T2 : T3;
  assign cpu_ce   = ce_q;
  assign mode     = mode_q;
  assign tick_cnt = tick_q;
  // Synchronize the run switch and remember the last rate select to spot changes
  always_ff @(posedge clk_board) begin
    if (!rst_n) begin
      run_s0_q <= 1'b0;
      run_s1_q <= 1'b0;
      sel_q    <= 2'd0;
    end else begin
      run_s0_q <= run_sw;
      run_s1_q <= run_s0_q;
      sel_q    <= div_sel;
    end
  end
  // Mode FSM with divider and pulse counter; halt_req beats run_sw beats terminal count
  always_ff @(posedge clk_board) begin
    if (!rst_n) begin
      mode_q <= HALT;
      ce_q   <= 1'b0;
      cnt_q  <= '0;
      tick_q <= '0;
    end else begin
      ce_q  <= 1'b0;
      cnt_q <= '0;
      unique case (mode_q)
        HALT:
          if (run_s1_q) mode_q <= RUN;
          else if (step_ev) begin
            mode_q <= STEP;
            ce_q   <= 1'b1;
            tick_q <= tick_q + 32'd1;
          end
        RUN:
          if (halt_req) mode_q <= CPU_HALT;
          else if (!run_s1_q) mode_q <= HALT;
          else if (div_sel == sel_q) begin
            if (cnt_q == tsel) begin
              ce_q   <= 1'b1;
              tick_q <= tick_q + 32'd1;
            end else cnt_q <= cnt_q + 32'd1;
          end
        STEP: mode_q <= HALT;
        CPU_HALT: if (!run_s1_q) mode_q <= HALT;
      endcase
    end
  end
endmodule

// File: doc/cpu_clock_ctrl.md
# cpu_clock_ctrl

Run/halt/single-step controller for the CPU clock domain, driven from the board clock. It produces a one-cycle clock-enable pulse `cpu_ce` at a selectable divided rate in RUN mode, or exactly one pulse per debounced step-button press in HALT mode. A CPU-originated halt request stops pulse generation. It sits between the board clock/board inputs and the CPU core's enable input.

## Interface
- `DIV0`, default 500000: `clk_board` cycles per `cpu_ce` pulse, `div_sel`=0
- `DIV1`, default 50000: cycles per pulse, `div_sel`=1
- `DIV2`, default 5000: cycles per pulse, `div_sel`=2
- `DIV3`, default 1: cycles per pulse, `div_sel`=3 (every cycle)
- `DEB_CYCLES`, default 1000000: cycles `step_btn` must be stable before the debounced level changes
- `clk_board`  in  1  board clock; sole clock
- `rst_n`  in  1  reset, synchronous, active-low
- `run_sw`  in  1  level; 1 requests RUN
- `step_btn`  in  1  raw step pushbutton; asynchronous, bouncy
- `div_sel`  in  2  rate select for RUN
- `halt_req`  in  1  CPU halt request; level, sampled every cycle
- `cpu_ce`  out  1  one-cycle CPU clock enable
- `mode`  out  2  0=HALT, 1=RUN, 2=STEP, 3=HALTED_BY_CPU
- `tick_cnt`  out  32  number of `cpu_ce` pulses issued since reset; wraps

## Operation
- Input conditioning: `step_btn` passes through a 2-flop synchronizer, then the debouncer. The debounced level changes only after `DEB_CYCLES` consecutive equal synchronized samples. A debounced rising edge is a step event. `run_sw` is 2-flop synchronized.
- FSM states: HALT, RUN, STEP, CPU_HALT.
  - HALT: sync `run_sw`=1 -> RUN. Otherwise, a step event -> STEP.
  - RUN: `halt_req`=1 -> CPU_HALT. Otherwise, sync `run_sw`=0 -> HALT. Otherwise emit `cpu_ce` when the divider terminal count is reached.
  - STEP: assert `cpu_ce` for exactly one cycle, then go to HALT unconditionally. Step events are ignored while in STEP.
  - CPU_HALT: no pulses. Leave only when sync `run_sw`=0, going to HALT. A re-raise of `run_sw` is therefore required to resume. Step events are ignored.
- Divider: `div_cnt` counts 0..DIVn-1 while in RUN and is held at 0 in every other state.
  - `cpu_ce`=1 in the cycle where `div_cnt`==DIVn-1; the counter wraps to 0 in the same cycle.
  - A `div_sel` change while in RUN resets `div_cnt` to 0 on the next cycle, with no pulse in that cycle.
  - DIVn=1 gives `cpu_ce` high on every RUN cycle.
- Priority within RUN in a single cycle: `halt_req` > `run_sw`=0 > terminal count. When `halt_req` coincides with terminal count, no pulse is issued.
- `tick_cnt` increments by 1 on every cycle where `cpu_ce`=1; it wraps from 0xFFFFFFFF to 0.
- DIVn=0 is illegal and behaves as DIVn=1.

## Timing
- Reset (`rst_n`=0 at a `clk_board` edge) gives:
  - `mode`=HALT, `cpu_ce`=0, `tick_cnt`=0, `div_cnt`=0
  - synchronizers and debouncer cleared to 0; debounce counter 0
- Reset is honoured mid-pulse and mid-debounce. No `cpu_ce` pulse appears in the cycle after reset.
- `cpu_ce`, `mode` and `tick_cnt` are registered outputs.
- `run_sw` latency: 2 sync cycles + 1 FSM cycle, so `mode` becomes RUN 3 cycles after `run_sw` rises. The first pulse follows DIVn cycles after that.
- Step latency: 2 sync + `DEB_CYCLES` + 1 edge-detect + 1 (STEP) cycles to the `cpu_ce` pulse. The pulse is exactly 1 cycle wide.
- `halt_req` is not synchronized (same clock). `mode`=CPU_HALT the cycle after `halt_req` is sampled high.

## Structure
- Shared package `clk_ctrl_pkg`: mode enum `mode_t` (HALT, RUN, STEP, CPU_HALT) and the default DIVn localparams.
- One sub-module: `debounce`, containing the synchronizer, stability counter and rising-edge pulse output. It is reusable for the other board buttons.
- The FSM, divider and tick counter live in `cpu_clock_ctrl`.

## Test plan
All scenarios use DIV0..3 = 8,4,2,1 and DEB_CYCLES = 4.
- Reset then `run_sw`=1, `div_sel`=1 -> `mode`=RUN at cycle 3; `cpu_ce` pulses every 4th cycle; `tick_cnt`=5 after 20 RUN cycles.
- HALT, `step_btn` bounced 1/0 for 3 cycles, then held high for 10 cycles -> exactly one `cpu_ce` pulse; `tick_cnt`=1; `mode` back to HALT.
- RUN with `div_sel`=3 and `halt_req` pulsed for 1 cycle -> `cpu_ce` low from that cycle on; `mode`=CPU_HALT. Stays halted while `run_sw`=1. `run_sw` 0 then 1 -> RUN again.
- RUN, `div_sel` changed 0->2 at `div_cnt`=5 -> no pulse that cycle; next pulse 2 cycles after the change.
- `tick_cnt` preloaded near wrap (force 0xFFFFFFFE), then 3 pulses -> reads 0x00000001.
- `rst_n`=0 asserted mid-debounce and in a `cpu_ce` cycle -> all outputs 0 / HALT next cycle; no pulse for that held press after release.
